lsu_mem_initiator: RTL and testbench
====================================

Name: lsu_mem_initiator

Overview:
- Load/store unit that sits between the core's execute stage and the byte-addressed data memory.
- Accepts one load/store request at a time over a valid/ready handshake.
- Drives the memory port (address, write_data, mem_write, mem_read, func3); write is synchronous, read is combinational.
- Splits misaligned halfword/word accesses into sequential byte accesses, reassembles load data, sign/zero-extends it, and flags illegal or out-of-range requests.

Parameters:
- MEM_BYTES, 1024, size of target memory in bytes; any access touching a byte at or above this is a fault.
- ALLOW_MISALIGNED, 1, 1 = split misaligned accesses into byte accesses; 0 = report misaligned accesses as faults.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request (IDLE only).
- req_we  input  1  1 = store, 0 = load.
- req_func3  input  3  RISC-V load/store func3.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, aligned to bit 0.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load data; 0 for stores and faults.
- resp_err  output  1  fault flag, valid with resp_valid.
- mem_address  output  32  to memory address.
- mem_write_data  output  32  to memory write_data.
- mem_write  output  1  to memory mem_write.
- mem_read  output  1  to memory mem_read.
- mem_func3  output  3  to memory func3.
- mem_read_data  input  32  from memory read_data (combinational).

Behaviour:
- States: IDLE, ACCESS, SPLIT, RESP.
- Reset (async) forces IDLE. All mem_* outputs, resp_valid, resp_rdata and resp_err go to 0; req_ready = 1.
- IDLE:
  - req_ready = 1 and all mem_* outputs are 0.
  - On a rising edge with req_valid = 1, latch we/func3/addr/wdata and classify:
    - Legal loads: 000, 001, 010, 100, 101. Legal stores: 000, 001, 010. Anything else is illegal.
    - size N = 1 (byte), 2 (half) or 4 (word).
    - Out of range: addr + N > MEM_BYTES, computed in 33 bits (no wrap).
    - Misaligned: half with addr[0] = 1; word with addr[1:0] != 0.
  - Illegal, out-of-range, or (misaligned and ALLOW_MISALIGNED = 0) -> RESP with err = 1. No mem strobe is ever asserted for these.
  - Aligned -> ACCESS. Misaligned -> SPLIT with cnt = 0.
- ACCESS: exactly one cycle.
  - mem_address = addr, mem_func3 = func3, mem_write_data = wdata.
  - mem_write = we; mem_read = !we.
  - Loads capture mem_read_data at the closing edge.
  - Next state: RESP.
- SPLIT: one cycle per byte, cnt from 0 to N-1.
  - mem_address = addr + cnt.
  - Stores: mem_func3 = 000, mem_write_data[7:0] = wdata byte cnt, upper bits 0.
  - Loads: mem_func3 = 100; mem_read_data[7:0] is captured into byte lane cnt of the assembly register.
  - At cnt == N-1, go to RESP.
- RESP: exactly one cycle.
  - resp_valid = 1 and all mem_* outputs are 0.
  - Load rdata: for SPLIT loads, sign-extend from bit 15 for func3 001, zero-extend for 101, pass through for 010. ACCESS loads pass the captured memory data through unchanged (memory already extended).
  - Next state: IDLE. There is no response backpressure.
- Latency, counted from the acceptance edge to resp_valid high:
  - Aligned access: 2 cycles.
  - Misaligned access: N + 1 cycles.
  - Fault: 1 cycle.
- Throughput: the next request is accepted the cycle after RESP; req_valid during RESP is ignored, since req_ready = 0.
- Mid-operation reset: mem_write drops immediately. Bytes already written by SPLIT stay written; there is no rollback. The in-flight request is discarded with no response.

Test Plan:
- Aligned path:
  - SW 0xDEADBEEF @0x010 -> one mem_write cycle, func3 010.
  - Then LW @0x010 -> resp_rdata 0xDEADBEEF, resp_err 0, 2-cycle latency.
- Misaligned store/load:
  - SW 0xA1B2C3D4 @0x003 -> four SB cycles at 0x003..0x006 with data D4, C3, B2, A1.
  - Then LW @0x003 -> 0xA1B2C3D4 after 5 cycles.
- Misaligned half:
  - After the above, LH @0x005 -> 0xFFFFA1B2.
  - LHU @0x005 -> 0x0000A1B2.
  - Each does 2 byte reads; resp after 3 cycles.
- Faults:
  - LW @0x3FE -> resp_err 1, resp_rdata 0.
  - Load func3 011 -> resp_err 1.
  - Store func3 100 -> resp_err 1.
  - Each with latency 1 and mem_read/mem_write never asserted.
- ALLOW_MISALIGNED = 0: SH @0x001 -> resp_err 1, no memory write.
- Reset mid-split: SW 0x11223344 @0x021, assert rst after 2 byte-write edges -> mem_write low immediately; only 0x021 = 44 and 0x022 = 33 written; no resp_valid; req_ready = 1 after release.

Source files
------------

// File: rtl/lsu_mem_initiator_if.sv
// Request/response handshake plus byte-addressed memory port of the load/store unit.
// The slave modport is the unit's view; master is the core/memory side.
interface lsu_mem_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [2:0]  mem_func3;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_we, req_func3, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_address, mem_write_data, mem_write, mem_read, mem_func3
  );

  modport master (
    output req_valid, req_we, req_func3, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_address, mem_write_data, mem_write, mem_read, mem_func3
  );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Load/store unit: one request at a time, misaligned accesses split into byte accesses,
// load data reassembled and extended, illegal/out-of-range requests answered with an error.
module lsu_mem_initiator #(
  parameter int unsigned MEM_BYTES        = 1024,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  lsu_mem_initiator_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StAccess, StSplit, StResp} state_e;

  state_e      state_q;
  logic        we_q;
  logic [2:0]  func3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  cnt_q;
  logic [1:0]  last_q;
  logic [31:0] asm_q;

  logic        req_ready_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] mem_address_q;
  logic [31:0] mem_write_data_q;
  logic        mem_write_q;
  logic        mem_read_q;
  logic [2:0]  mem_func3_q;

  // Classification of the request presented on the bus.
  logic        req_legal;
  logic [2:0]  req_size;
  logic [32:0] req_end;
  logic        req_oor;
  logic        req_mis;
  logic        req_fault;

  always_comb begin
    case (bus_io.req_func3[1:0])
      2'b01:   req_size = 3'd2;
      2'b10:   req_size = 3'd4;
      default: req_size = 3'd1;
    endcase
    if (bus_io.req_we) begin
      req_legal = bus_io.req_func3 inside {3'b000, 3'b001, 3'b010};
    end else begin
      req_legal = bus_io.req_func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
    // 33-bit sum so addresses near 2^32 cannot wrap back into range.
    req_end   = {1'b0, bus_io.req_addr} + 33'(req_size);
    req_oor   = req_end > 33'(MEM_BYTES);
    req_mis   = ((req_size == 3'd2) && bus_io.req_addr[0]) ||
                ((req_size == 3'd4) && (bus_io.req_addr[1:0] != 2'b00));
    req_fault = !req_legal || req_oor || (req_mis && !ALLOW_MISALIGNED);
  end

  // Split datapath: next byte index, byte-lane merge and final extension.
  logic [1:0]  cnt_nxt;
  logic [31:0] asm_nxt;
  logic [31:0] load_ext;
  logic [7:0]  wbyte_nxt;

  always_comb begin
    cnt_nxt = cnt_q + 2'd1;
    asm_nxt = asm_q;
    asm_nxt[{cnt_q, 3'b000} +: 8] = bus_io.mem_read_data[7:0];
    case (func3_q)
      3'b001:  load_ext = {{16{asm_nxt[15]}}, asm_nxt[15:0]};
      3'b101:  load_ext = {16'h0000, asm_nxt[15:0]};
      default: load_ext = asm_nxt;
    endcase
    wbyte_nxt = wdata_q[{cnt_nxt, 3'b000} +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      we_q             <= 1'b0;
      func3_q          <= 3'b000;
      addr_q           <= 32'h0;
      wdata_q          <= 32'h0;
      cnt_q            <= 2'd0;
      last_q           <= 2'd0;
      asm_q            <= 32'h0;
      req_ready_q      <= 1'b1;
      resp_valid_q     <= 1'b0;
      resp_err_q       <= 1'b0;
      resp_rdata_q     <= 32'h0;
      mem_address_q    <= 32'h0;
      mem_write_data_q <= 32'h0;
      mem_write_q      <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_func3_q      <= 3'b000;
    end else begin
      // Outputs default to their quiet values; each state raises only what it owns.
      req_ready_q      <= 1'b0;
      resp_valid_q     <= 1'b0;
      resp_err_q       <= 1'b0;
      resp_rdata_q     <= 32'h0;
      mem_address_q    <= 32'h0;
      mem_write_data_q <= 32'h0;
      mem_write_q      <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_func3_q      <= 3'b000;

      case (state_q)
        StIdle: begin
          if (bus_io.req_valid) begin
            we_q    <= bus_io.req_we;
            func3_q <= bus_io.req_func3;
            addr_q  <= bus_io.req_addr;
            wdata_q <= bus_io.req_wdata;
            cnt_q   <= 2'd0;
            last_q  <= req_size[2] ? 2'd3 : 2'd1;
            asm_q   <= 32'h0;
            if (req_fault) begin
              state_q      <= StResp;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (req_mis) begin
              state_q          <= StSplit;
              mem_address_q    <= bus_io.req_addr;
              mem_func3_q      <= bus_io.req_we ? 3'b000 : 3'b100;
              mem_write_data_q <= bus_io.req_we ? {24'h0, bus_io.req_wdata[7:0]} : 32'h0;
              mem_write_q      <= bus_io.req_we;
              mem_read_q       <= !bus_io.req_we;
            end else begin
              state_q          <= StAccess;
              mem_address_q    <= bus_io.req_addr;
              mem_func3_q      <= bus_io.req_func3;
              mem_write_data_q <= bus_io.req_wdata;
              mem_write_q      <= bus_io.req_we;
              mem_read_q       <= !bus_io.req_we;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end

        StAccess: begin
          // Memory has already extended the loaded value.
          if (!we_q) begin
            asm_q <= bus_io.mem_read_data;
          end
          state_q      <= StResp;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= we_q ? 32'h0 : bus_io.mem_read_data;
        end

        StSplit: begin
          if (!we_q) begin
            asm_q <= asm_nxt;
          end
          if (cnt_q == last_q) begin
            state_q      <= StResp;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= we_q ? 32'h0 : load_ext;
          end else begin
            cnt_q            <= cnt_nxt;
            mem_address_q    <= addr_q + {30'h0, cnt_nxt};
            mem_func3_q      <= we_q ? 3'b000 : 3'b100;
            mem_write_data_q <= we_q ? {24'h0, wbyte_nxt} : 32'h0;
            mem_write_q      <= we_q;
            mem_read_q       <= !we_q;
          end
        end

        StResp: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
        end

        default: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus_io.req_ready      = req_ready_q;
  assign bus_io.resp_valid     = resp_valid_q;
  assign bus_io.resp_err       = resp_err_q;
  assign bus_io.resp_rdata     = resp_rdata_q;
  assign bus_io.mem_address    = mem_address_q;
  assign bus_io.mem_write_data = mem_write_data_q;
  assign bus_io.mem_write      = mem_write_q;
  assign bus_io.mem_read       = mem_read_q;
  assign bus_io.mem_func3      = mem_func3_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: byte-array memory, request-level reference model producing
// a per-cycle expected trace, literal expectations pinning the model.
module tb_lsu_mem_initiator;

  localparam int unsigned MemBytes = 1024;

  typedef struct packed {
    logic        ready;
    logic        rv;
    logic        err;
    logic [31:0] rdata;
    logic        mw;
    logic        mr;
    logic [31:0] ma;
    logic [2:0]  mf;
    logic [31:0] mwd;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  logic mem_clr;
  always #5 clk = ~clk;

  lsu_mem_initiator_if mif ();
  lsu_mem_initiator_if nif ();

  lsu_mem_initiator #(.MEM_BYTES(MemBytes), .ALLOW_MISALIGNED(1'b1)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(mif)
  );

  lsu_mem_initiator #(.MEM_BYTES(MemBytes), .ALLOW_MISALIGNED(1'b0)) dut_nm (
    .clk   (clk),
    .rst   (rst),
    .bus_io(nif)
  );

  // Target memory: synchronous write, combinational extended read.
  logic [7:0] mem [MemBytes];
  logic [9:0] ma;
  logic [7:0] b0, b1, b2, b3;

  always_comb begin
    ma = mif.mem_address[9:0];
    b0 = mem[ma];
    b1 = mem[10'(ma + 10'd1)];
    b2 = mem[10'(ma + 10'd2)];
    b3 = mem[10'(ma + 10'd3)];
    case (mif.mem_func3)
      3'b000:  mif.mem_read_data = {{24{b0[7]}}, b0};
      3'b001:  mif.mem_read_data = {{16{b1[7]}}, b1, b0};
      3'b010:  mif.mem_read_data = {b3, b2, b1, b0};
      3'b100:  mif.mem_read_data = {24'h0, b0};
      3'b101:  mif.mem_read_data = {16'h0, b1, b0};
      default: mif.mem_read_data = 32'h0;
    endcase
  end

  assign nif.mem_read_data = 32'h0;

  logic nm_strobe;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < MemBytes; i++) mem[i] <= 8'h00;
      nm_strobe <= 1'b0;
    end else begin
      if (nif.mem_write || nif.mem_read) nm_strobe <= 1'b1;
      if (mif.mem_write) begin
        case (mif.mem_func3)
          3'b000: mem[ma] <= mif.mem_write_data[7:0];
          3'b001: begin
            mem[ma]               <= mif.mem_write_data[7:0];
            mem[10'(ma + 10'd1)]  <= mif.mem_write_data[15:8];
          end
          3'b010: begin
            mem[ma]               <= mif.mem_write_data[7:0];
            mem[10'(ma + 10'd1)]  <= mif.mem_write_data[15:8];
            mem[10'(ma + 10'd2)]  <= mif.mem_write_data[23:16];
            mem[10'(ma + 10'd3)]  <= mif.mem_write_data[31:24];
          end
          default: ;
        endcase
      end
    end
  end

  // Reference model state.
  logic [7:0] ref_mem [MemBytes];
  obs_t exp_q[$];
  obs_t nexp_q[$];
  obs_t plan[$];
  int   checks;
  int   failures;
  bit   prev_early;

  function automatic obs_t idle_obs();
    obs_t o;
    o       = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  function automatic obs_t sample(input bit inst);
    obs_t o;
    if (inst) begin
      o = {nif.req_ready, nif.resp_valid, nif.resp_err, nif.resp_rdata, nif.mem_write,
           nif.mem_read, nif.mem_address, nif.mem_func3, nif.mem_write_data};
    end else begin
      o = {mif.req_ready, mif.resp_valid, mif.resp_err, mif.resp_rdata, mif.mem_write,
           mif.mem_read, mif.mem_address, mif.mem_func3, mif.mem_write_data};
    end
    return o;
  endfunction

  task automatic cmp_one(input bit inst, input obs_t e);
    obs_t a;
    a = sample(inst);
    // Write-data lines carry no meaning on read beats.
    if (e.mr) a.mwd = e.mwd;
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL cycle_%s t=%0t got rdy=%b rv=%b err=%b rd=%h mw=%b mr=%b a=%h f=%h wd=%h want rdy=%b rv=%b err=%b rd=%h mw=%b mr=%b a=%h f=%h wd=%h",
               inst ? "nm" : "dut", $time, a.ready, a.rv, a.err, a.rdata, a.mw, a.mr, a.ma,
               a.mf, a.mwd, e.ready, e.rv, e.err, e.rdata, e.mw, e.mr, e.ma, e.mf, e.mwd);
    end
  endtask

  task automatic compare_cycle();
    obs_t e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : idle_obs();
    cmp_one(1'b0, e);
    e = (nexp_q.size() != 0) ? nexp_q.pop_front() : idle_obs();
    cmp_one(1'b1, e);
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
  endtask

  // Request-level model: outcome plus the bus beats it must produce.
  task automatic build(input bit allow, input bit we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output bit err, output logic [31:0] rdata);
    int          size;
    bit          legal, mis;
    logic [31:0] raw;
    obs_t        b;
    plan.delete();
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis   = (addr % 32'(size)) != 0;
    err   = !legal || (longint'(addr) + longint'(size) > longint'(MemBytes)) || (mis && !allow);
    rdata = 32'h0;
    if (!err && !we) begin
      raw = 32'h0;
      for (int i = 0; i < size; i++) raw[8*i +: 8] = ref_mem[addr + 32'(i)];
      case (f3)
        3'd0:    rdata = {{24{raw[7]}}, raw[7:0]};
        3'd1:    rdata = {{16{raw[15]}}, raw[15:0]};
        3'd4:    rdata = {24'h0, raw[7:0]};
        3'd5:    rdata = {16'h0, raw[15:0]};
        default: rdata = raw;
      endcase
    end
    if (err) begin
      lat = 1;
    end else if (!mis) begin
      lat   = 2;
      b     = '0;
      b.mw  = we;
      b.mr  = !we;
      b.ma  = addr;
      b.mf  = f3;
      b.mwd = we ? wdata : 32'h0;
      plan.push_back(b);
    end else begin
      lat = size + 1;
      for (int i = 0; i < size; i++) begin
        b     = '0;
        b.mw  = we;
        b.mr  = !we;
        b.ma  = addr + 32'(i);
        b.mf  = we ? 3'b000 : 3'b100;
        b.mwd = we ? ((wdata >> (8 * i)) & 32'hFF) : 32'h0;
        plan.push_back(b);
      end
    end
    b       = '0;
    b.rv    = 1'b1;
    b.err   = err;
    b.rdata = rdata;
    plan.push_back(b);
  endtask

  task automatic drive(input bit inst, input bit v, input bit we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (inst) begin
      nif.req_valid = v; nif.req_we = we; nif.req_func3 = f3;
      nif.req_addr = addr; nif.req_wdata = wdata;
    end else begin
      mif.req_valid = v; mif.req_we = we; mif.req_func3 = f3;
      mif.req_addr = addr; mif.req_wdata = wdata;
    end
  endtask

  // early = leave while the response cycle is still showing, so the next request is
  // presented during it and must be held for an extra cycle.
  task automatic do_req(input bit inst, input bit we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit early,
                        input logic [31:0] lit_rdata, input int lit_lat, input bit lit_err);
    int          lat;
    bit          err;
    logic [31:0] rdata;
    int          hold;
    build(!inst, we, f3, addr, wdata, lat, err, rdata);
    checks++;
    if (lat != lit_lat || err != lit_err || rdata !== lit_rdata) begin
      failures++;
      $display("FAIL model_a%h_f%0d got lat=%0d err=%b rd=%h want lat=%0d err=%b rd=%h",
               addr, f3, lat, err, rdata, lit_lat, lit_err, lit_rdata);
    end
    if (!err && we) begin
      for (int i = 0; i < plan.size() - 1; i++) ref_mem[plan[i].ma] = plan[i].mwd[7:0];
      if (plan.size() == 2) begin
        for (int i = 0; i < lat * 0 + ((f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4); i++)
          ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
      end
    end
    if (inst) begin
      nexp_q.push_back(idle_obs());
      foreach (plan[i]) nexp_q.push_back(plan[i]);
    end else begin
      exp_q.push_back(idle_obs());
      foreach (plan[i]) exp_q.push_back(plan[i]);
    end
    hold = prev_early ? 2 : 1;
    drive(inst, 1'b1, we, f3, addr, wdata);
    repeat (hold) tick();
    drive(inst, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (early ? lat - 1 : lat) tick();
    prev_early = early;
  endtask

  task automatic check_byte(input int a, input logic [7:0] want);
    checks++;
    if (mem[a] !== want) begin
      failures++;
      $display("FAIL mem_byte_%h got %h want %h", a, mem[a], want);
    end
  endtask

  initial begin
    int          lat;
    bit          err;
    logic [31:0] rdata;
    checks     = 0;
    failures   = 0;
    prev_early = 1'b0;
    for (int i = 0; i < MemBytes; i++) ref_mem[i] = 8'h00;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    rst     = 1'b1;
    mem_clr = 1'b1;
    repeat (3) tick();
    mem_clr = 1'b0;
    rst     = 1'b0;
    repeat (2) tick();

    //     inst we   f3      addr           wdata          early rdata          lat err
    do_req(0,   1,   3'd2,   32'h010,       32'hDEADBEEF,  0,    32'h0,         2,  0);
    do_req(0,   0,   3'd2,   32'h010,       32'h0,         1,    32'hDEADBEEF,  2,  0);
    do_req(0,   1,   3'd2,   32'h003,       32'hA1B2C3D4,  0,    32'h0,         5,  0);
    do_req(0,   0,   3'd2,   32'h003,       32'h0,         0,    32'hA1B2C3D4,  5,  0);
    do_req(0,   0,   3'd1,   32'h005,       32'h0,         1,    32'hFFFFA1B2,  3,  0);
    do_req(0,   0,   3'd5,   32'h005,       32'h0,         0,    32'h0000A1B2,  3,  0);
    do_req(0,   0,   3'd2,   32'h3FE,       32'h0,         1,    32'h0,         1,  1);
    do_req(0,   0,   3'd3,   32'h000,       32'h0,         0,    32'h0,         1,  1);
    do_req(0,   1,   3'd4,   32'h000,       32'h12345678,  0,    32'h0,         1,  1);
    do_req(0,   0,   3'd2,   32'hFFFFFFFC,  32'h0,         0,    32'h0,         1,  1);
    do_req(0,   0,   3'd2,   32'h3FC,       32'h0,         0,    32'h0,         2,  0);
    do_req(0,   1,   3'd0,   32'h3FF,       32'hFFFFFF80,  0,    32'h0,         2,  0);
    do_req(0,   1,   3'd1,   32'h3FF,       32'h00001234,  0,    32'h0,         1,  1);
    do_req(0,   0,   3'd0,   32'h3FF,       32'h0,         1,    32'hFFFFFF80,  2,  0);
    do_req(0,   0,   3'd4,   32'h3FF,       32'h0,         0,    32'h00000080,  2,  0);
    do_req(0,   1,   3'd1,   32'h007,       32'h0000BEEF,  0,    32'h0,         3,  0);
    do_req(0,   0,   3'd1,   32'h007,       32'h0,         0,    32'hFFFFBEEF,  3,  0);
    do_req(0,   0,   3'd2,   32'h004,       32'h0,         0,    32'hEFA1B2C3,  2,  0);
    do_req(1,   1,   3'd1,   32'h001,       32'h00005555,  0,    32'h0,         1,  1);
    tick();

    // Reset two byte-writes into a misaligned word store.
    build(1'b1, 1'b1, 3'd2, 32'h021, 32'h11223344, lat, err, rdata);
    exp_q.push_back(idle_obs());
    exp_q.push_back(plan[0]);
    exp_q.push_back(plan[1]);
    drive(1'b0, 1'b1, 1'b1, 3'd2, 32'h021, 32'h11223344);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (2) tick();
    rst = 1'b1;
    exp_q.delete();
    ref_mem[32'h021] = 8'h44;
    ref_mem[32'h022] = 8'h33;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    check_byte(32'h021, 8'h44);
    check_byte(32'h022, 8'h33);
    check_byte(32'h023, 8'h00);
    check_byte(32'h024, 8'h00);
    do_req(0, 0, 3'd2, 32'h020, 32'h0, 0, 32'h00334400, 2, 0);
    check_byte(32'h3FF, 8'h80);
    repeat (2) tick();

    checks++;
    if (nm_strobe !== 1'b0) begin
      failures++;
      $display("FAIL nm_no_strobe got %b want 0", nm_strobe);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
